tristate_bus_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for a shared tristate net driven by N

---
 rtl/tristate_bus_arbiter_pkg.sv | 16 +
 rtl/tristate_bus_arbiter_if.sv | 13 +
 rtl/tristate_bus_arbiter_rr_pick.sv | 28 ++
 rtl/tristate_bus_arbiter.sv | 114 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 133 +++++++++++++
 5 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and elaboration helpers for the tristate bus arbiter.
// Every counter width comes from width_of, so no field is ever narrower than 1 bit.
package tristate_bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} arb_state_e;

  function automatic int width_of(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  function automatic bit params_ok(input int n, input int ta, input int max_hold);
    return (n >= 2) && (n <= 16) && (ta >= 1) && (ta <= 15) &&
           (max_hold >= 0) && (max_hold <= 255);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between the requesters, the arbiter and the bufz bank.
interface tristate_bus_arbiter_if #(parameter int N = 4);

  logic [N-1:0]                                 req;
  logic [N-1:0]                                 en;
  logic [tristate_bus_arb_pkg::width_of(N)-1:0] owner;
  logic                                         busy;
  logic                                         turn;

  modport master (input req, output en, owner, busy, turn);
  modport slave  (output req, input en, owner, busy, turn);

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  logic [PW-1:0] idx;

  // The search runs from the farthest position back towards ptr, so the
  // position closest to ptr is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate net, with registered bufz enables
// and break-before-make turnaround cycles between owners.
module tristate_bus_arbiter
  import tristate_bus_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int TA       = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_arbiter_if.master bus
);

  localparam int PW = width_of(N);
  localparam int HW = width_of(MAX_HOLD + 1);
  localparam int TW = width_of(TA + 1);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  if (!params_ok(N, TA, MAX_HOLD)) begin : g_bad_params
    $error("tristate_bus_arbiter: parameter out of range");
  end

  arb_state_e    state;
  logic [PW-1:0] ptr;
  logic [HW-1:0] hold;
  logic [TW-1:0] turn_cnt;
  logic [N-1:0]  en_q;
  logic [PW-1:0] owner_q;
  logic          busy_q;
  logic          turn_q;

  logic [PW-1:0] win;
  logic          win_valid;
  logic          release_now;
  logic [PW-1:0] next_ptr;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  assign release_now = !bus.req[owner_q] ||
                       ((MAX_HOLD != 0) && (hold == HW'(MAX_HOLD)));
  assign next_ptr    = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold     <= '0;
      turn_cnt <= '0;
      en_q     <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      turn_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            en_q    <= ONE_HOT0 << win;
            owner_q <= win;
            busy_q  <= 1'b1;
            hold    <= HW'(1);
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (release_now) begin
            en_q     <= '0;
            busy_q   <= 1'b0;
            turn_q   <= 1'b1;
            ptr      <= next_ptr;
            turn_cnt <= TW'(TA);
            state    <= TURN;
          end else if (hold != {HW{1'b1}}) begin
            hold <= hold + 1'b1;
          end
        end
        TURN: begin
          turn_cnt <= turn_cnt - 1'b1;
          // Requests are only looked at on the last dead cycle.
          if (turn_cnt == TW'(1)) begin
            turn_q <= 1'b0;
            if (win_valid) begin
              en_q    <= ONE_HOT0 << win;
              owner_q <= win;
              busy_q  <= 1'b1;
              hold    <= HW'(1);
              state   <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.en    = en_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.turn  = turn_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(en_q));
  a_busy:   assert property (@(posedge clk) disable iff (rst) busy_q == (|en_q));
  a_turn:   assert property (@(posedge clk) disable iff (rst) turn_q |-> (en_q == '0));
  a_bbm:    assert property (@(posedge clk) disable iff (rst)
                             ((en_q != '0) && ($past(en_q) != '0)) |-> (en_q == $past(en_q)));

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed scoreboard bench: two arbiters (MAX_HOLD=4 and unlimited), TA=2, N=4.
module tb_tristate_bus_arbiter;

  typedef struct packed {
    logic       sel;
    logic [3:0] en;
    logic [1:0] owner;
    logic       busy;
    logic       turn;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  tristate_bus_arbiter_if #(.N(4)) bus_a ();
  tristate_bus_arbiter_if #(.N(4)) bus_u ();

  tristate_bus_arbiter #(.N(4), .TA(2), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  tristate_bus_arbiter #(.N(4), .TA(2), .MAX_HOLD(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus_u.master)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [3:0] rq,
                               input logic [3:0] e, input int o, input logic t);
    exp_t x;
    @(negedge clk);
    rst = r;
    if (s) begin
      bus_u.req = rq;
      bus_a.req = '0;
    end else begin
      bus_a.req = rq;
      bus_u.req = '0;
    end
    x.sel   = s;
    x.en    = e;
    x.owner = 2'(o);
    x.busy  = (e != 4'b0000);
    x.turn  = t;
    sb.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    exp_t got;
    got.sel = x.sel;
    if (x.sel) begin
      got.en = bus_u.en; got.owner = bus_u.owner; got.busy = bus_u.busy; got.turn = bus_u.turn;
    end else begin
      got.en = bus_a.en; got.owner = bus_a.owner; got.busy = bus_a.busy; got.turn = bus_a.turn;
    end
    checks++;
    if (got === x) begin
      passed++;
    end else begin
      $display("[TB] FAIL step%0d dut%0d: got en=%b owner=%0d busy=%b turn=%b, expected en=%b owner=%0d busy=%b turn=%b",
               checks, x.sel, got.en, got.owner, got.busy, got.turn,
               x.en, x.owner, x.busy, x.turn);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        checkOutput(sb.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus_a.req = '0;
    bus_u.req = '0;

    repeat (3) applyStimulus(1, 0, 4'b1111, 4'b0000, 0, 0);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 0);

    repeat (2) applyStimulus(0, 0, 4'b0100, 4'b0100, 2, 0);
    repeat (2) applyStimulus(0, 0, 4'b0000, 4'b0000, 2, 1);
    repeat (2) applyStimulus(0, 0, 4'b0000, 4'b0000, 2, 0);

    // ptr sits at 3 after owner 2 released, so rotation runs 3,0,1,2,3.
    for (int k = 0; k < 5; k++) begin
      int o;
      o = (3 + k) % 4;
      repeat (4) applyStimulus(0, 0, 4'b1111, 4'(1 << o), o, 0);
      repeat (2) applyStimulus(0, 0, 4'b1111, 4'b0000, o, 1);
    end

    for (int r = 0; r < 2; r++) begin
      repeat (4) applyStimulus(0, 0, 4'b0001, 4'b0001, 0, 0);
      repeat (2) applyStimulus(0, 0, 4'b0001, 4'b0000, 0, 1);
    end

    // A stale ptr of 1 would pick 3 from 4'b1001; a cleared ptr picks 0.
    repeat (2) applyStimulus(0, 0, 4'b1000, 4'b1000, 3, 0);
    applyStimulus(1, 0, 4'b1000, 4'b0000, 0, 0);
    repeat (4) applyStimulus(0, 0, 4'b1001, 4'b0001, 0, 0);
    repeat (2) applyStimulus(0, 0, 4'b1001, 4'b0000, 0, 1);
    applyStimulus(0, 0, 4'b1001, 4'b1000, 3, 0);
    repeat (2) applyStimulus(0, 0, 4'b0000, 4'b0000, 3, 1);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 3, 0);

    repeat (8) applyStimulus(0, 1, 4'b1010, 4'b0010, 1, 0);
    repeat (2) applyStimulus(0, 1, 4'b1000, 4'b0000, 1, 1);
    repeat (3) applyStimulus(0, 1, 4'b1000, 4'b1000, 3, 0);
    repeat (2) applyStimulus(0, 1, 4'b0000, 4'b0000, 3, 1);
    applyStimulus(0, 1, 4'b0000, 4'b0000, 3, 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
